// File: rtl/lfsr_floor_scheduler_pkg.sv
// Shared types, LFSR constants and the LFSR step function for the floor scheduler.
package scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      GRANT = 2'd2
   } state_e;

   localparam int unsigned LFSR_W = 10;
   localparam int unsigned TAP_HI = 9;
   localparam int unsigned TAP_LO = 6;
   localparam logic [LFSR_W-1:0] LFSR_LOCK = 10'h3FF;

   // XNOR LFSR step; the all-ones lockup state is steered back to zero.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      if (q == LFSR_LOCK) begin
         return '0;
      end
      return {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
   endfunction

endpackage

// File: rtl/lfsr_floor_scheduler_if.sv
// Request/grant bundle between the requesters and the floor scheduler.
interface lfsr_floor_scheduler_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned FLOORS = 6
);
   import scheduler_pkg::*;

   localparam int unsigned VW = $clog2(FLOORS);

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  ack;
   logic [VW-1:0]     value;
   logic              busy;
   logic [LFSR_W-1:0] lfsr_q;

   modport master (output req, input ack, value, busy, lfsr_q);
   modport slave  (input req, output ack, value, busy, lfsr_q);

endinterface

// File: rtl/lfsr_floor_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] sel,
   output logic          any
);

   logic [PW-1:0] lo_sel;
   logic [PW-1:0] hi_sel;
   logic          hi_any;

   // Lowest set bit overall and lowest set bit at/above ptr; the latter wins.
   always_comb begin
      lo_sel = '0;
      hi_sel = '0;
      hi_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_sel = PW'(i);
            if (PW'(i) >= ptr) begin
               hi_sel = PW'(i);
               hi_any = 1'b1;
            end
         end
      end
      any = |req;
      sel = hi_any ? hi_sel : lo_sel;
   end

endmodule

// File: rtl/lfsr_floor_scheduler.sv
// Shares one free-running 10-bit XNOR LFSR among N_REQ requesters, drawing
// non-repeating floors with a bounded-latency fallback.
module lfsr_floor_scheduler
   import scheduler_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned FLOORS    = 6,
   parameter int unsigned MAX_TRIES = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   lfsr_floor_scheduler_if.slave  bus
);

   localparam int unsigned VW = $clog2(FLOORS);
   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TW = $clog2(MAX_TRIES + 1);

   localparam logic [VW:0]   FLOORS_X  = (VW+1)'(FLOORS);
   localparam logic [VW-1:0] FLOOR_MAX = VW'(FLOORS - 1);
   localparam logic [PW-1:0] PTR_MAX   = PW'(N_REQ - 1);

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_r;
   logic [LFSR_W-1:0] lfsr_cur;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     sel_q, sel_d;
   logic [PW-1:0]     arb_sel;
   logic              arb_any;
   logic [TW-1:0]     tries_q, tries_d, tries_inc;
   logic [VW-1:0]     floor_q, floor_d;
   logic [VW-1:0]     last_q, last_d;
   logic              last_vld_q, last_vld_d;
   logic [VW-1:0]     cand;
   logic [VW-1:0]     fallback;
   logic              cand_ok;
   logic [PW-1:0]     ptr_after;

   logic [N_REQ-1:0]  ack_r, ack_d;
   logic [VW-1:0]     value_r, value_d;
   logic              busy_r, busy_d;

   // Single tap point for the LFSR state so every consumer sees the same value.
   assign lfsr_cur = lfsr_r;

   assign bus.ack    = ack_r;
   assign bus.value  = value_r;
   assign bus.busy   = busy_r;
   assign bus.lfsr_q = lfsr_cur;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req (bus.req),
      .ptr (ptr_q),
      .sel (arb_sel),
      .any (arb_any)
   );

   // Candidate qualification: in range and not a repeat of the last granted floor.
   always_comb begin
      cand      = lfsr_cur[VW-1:0];
      cand_ok   = ({1'b0, cand} < FLOORS_X) && (!last_vld_q || (cand != last_q));
      fallback  = (!last_vld_q || (last_q == FLOOR_MAX)) ? '0 : last_q + VW'(1);
      tries_inc = tries_q + TW'(1);
      ptr_after = (sel_q == PTR_MAX) ? '0 : sel_q + PW'(1);
   end

   // LFSR free-runs in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= '0;
      end else begin
         lfsr_r <= lfsr_next(lfsr_cur);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      tries_d    = tries_q;
      floor_d    = floor_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      ack_d      = '0;
      value_d    = value_r;
      busy_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_any) begin
               sel_d   = arb_sel;
               tries_d = '0;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (!bus.req[sel_q]) begin
               state_d = IDLE;
            end else if (cand_ok) begin
               floor_d = cand;
               state_d = GRANT;
            end else begin
               tries_d = tries_inc;
               if (tries_inc == TW'(MAX_TRIES)) begin
                  floor_d = fallback;
                  state_d = GRANT;
               end
            end
         end
         GRANT: begin
            last_d     = floor_q;
            last_vld_d = 1'b1;
            ptr_d      = ptr_after;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      if (state_d == GRANT) begin
         ack_d   = N_REQ'(1) << sel_d;
         value_d = floor_d;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         ptr_q      <= '0;
         tries_q    <= '0;
         floor_q    <= '0;
         last_q     <= '0;
         last_vld_q <= 1'b0;
         ack_r      <= '0;
         value_r    <= '0;
         busy_r     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         tries_q    <= tries_d;
         floor_q    <= floor_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         ack_r      <= ack_d;
         value_r    <= value_d;
         busy_r     <= busy_d;
      end
   end

endmodule

// File: tb/tb_lfsr_floor_scheduler.sv
// Randomized bench for lfsr_floor_scheduler with a transaction-level reference model.
module tb_lfsr_floor_scheduler;

   localparam int N        = 4;
   localparam int FL       = 6;
   localparam int MT       = 8;
   localparam int CAND_MOD = 8;

   logic clk = 1'b0;
   logic reset;

   int checks   = 0;
   int failures = 0;

   logic [9:0] m_lfsr;
   int         m_ptr;
   int         m_last;
   bit         m_lvld;
   int         m_vout;
   bit         pv_valid;
   logic [2:0] pv_val;
   logic [9:0] lfsr_tab [0:9];

   lfsr_floor_scheduler_if #(.N_REQ(N), .FLOORS(FL)) sif  ();
   lfsr_floor_scheduler_if #(.N_REQ(N), .FLOORS(FL)) sif2 ();

   lfsr_floor_scheduler #(.N_REQ(N), .FLOORS(FL), .MAX_TRIES(MT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   lfsr_floor_scheduler #(.N_REQ(N), .FLOORS(FL), .MAX_TRIES(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (sif2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, req_v);
      end
   endtask

   function automatic logic [9:0] m_step(input logic [9:0] x);
      if (x == 10'h3FF) return 10'h000;
      return {x[8:0], ~(x[9] ^ x[6])};
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      m_lfsr = reset ? 10'h000 : m_step(m_lfsr);
      @(negedge clk);
      check("lfsr_q", 32'(sif.lfsr_q), 32'(m_lfsr));
   endtask

   task automatic sample(input string tag, input logic [N-1:0] e_ack, input logic e_busy);
      check($sformatf("%s.ack", tag), 32'(sif.ack), 32'(e_ack));
      check($sformatf("%s.busy", tag), 32'(sif.busy), 32'(e_busy));
      check($sformatf("%s.value", tag), 32'(sif.value), 32'(m_vout));
   endtask

   // One request cycle through to the following IDLE; abort_at<0 means no abort.
   task automatic run_txn(input logic [N-1:0] pat, input int abort_at);
      int sel;
      int tries;
      int floor_v;
      int j;
      bit done;
      sel      = rr_pick(pat, m_ptr);
      sif.req  = pat;
      tick();
      sample("draw_entry", '0, 1'b1);
      tries   = 0;
      j       = 0;
      done    = 0;
      floor_v = 0;
      while (!done) begin
         int cand;
         cand = int'(m_lfsr) % CAND_MOD;
         if (j == abort_at) begin
            sif.req = N'($urandom) & ~(N'(1) << sel);
            tick();
            sample("abort", '0, 1'b0);
            return;
         end
         sif.req = N'($urandom) | (N'(1) << sel);
         if (cand < FL && (!m_lvld || cand != m_last)) begin
            floor_v = cand;
            done    = 1;
         end else begin
            tries++;
            if (tries == MT) begin
               floor_v = m_lvld ? (m_last + 1) % FL : 0;
               done    = 1;
            end
         end
         tick();
         if (!done) sample("draw", '0, 1'b1);
         j++;
      end
      m_vout = floor_v;
      sample("grant", N'(1) << sel, 1'b1);
      if (pv_valid) check("no_repeat", 32'(sif.value == pv_val), 32'(0));
      pv_val   = sif.value;
      pv_valid = 1;
      m_last   = floor_v;
      m_lvld   = 1;
      m_ptr    = (sel + 1) % N;
      sif.req  = N'($urandom);
      tick();
      sample("idle", '0, 1'b0);
   endtask

   initial begin
      lfsr_tab = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                   10'h01F, 10'h03F, 10'h07F, 10'h0FE, 10'h1FC};
      reset    = 1'b1;
      sif.req  = '0;
      sif2.req = '0;
      m_lfsr   = '0;
      m_ptr    = 0;
      m_last   = 0;
      m_lvld   = 0;
      m_vout   = 0;
      pv_valid = 0;
      pv_val   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      // c0: reset values on both instances
      sample("rst", '0, 1'b0);
      check("rst.lfsr", 32'(sif.lfsr_q), 32'(0));
      check("rst2.ack", 32'(sif2.ack), 32'(0));
      check("rst2.busy", 32'(sif2.busy), 32'(0));
      check("rst2.value", 32'(sif2.value), 32'(0));
      check("rst2.lfsr", 32'(sif2.lfsr_q), 32'(0));
      reset    = 1'b0;
      sif.req  = 4'b0001;
      sif2.req = 4'b0001;

      // Directed: single draw, rejection run (MAX_TRIES=8) and fallback (MAX_TRIES=2)
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k <= 9) check($sformatf("dir.lfsr_c%0d", k), 32'(sif.lfsr_q), 32'(lfsr_tab[k]));
         check($sformatf("dir.ack_c%0d", k), 32'(sif.ack), 32'((k == 2 || k == 10) ? 1 : 0));
         check($sformatf("dir.busy_c%0d", k), 32'(sif.busy), 32'(k != 3));
         check($sformatf("dir.value_c%0d", k), 32'(sif.value), 32'((k < 2) ? 0 : (k < 10) ? 1 : 4));
         check($sformatf("fb.ack_c%0d", k), 32'(sif2.ack), 32'((k == 2 || k == 6) ? 1 : 0));
         check($sformatf("fb.busy_c%0d", k), 32'(sif2.busy), 32'((k <= 2) || (k >= 4 && k <= 6)));
         check($sformatf("fb.value_c%0d", k), 32'(sif2.value), 32'((k < 2) ? 0 : (k < 6) ? 1 : 2));
         if (k == 6) sif2.req = '0;
         if (k == 10) sif.req = '0;
      end
      m_vout   = 4;
      m_last   = 4;
      m_lvld   = 1;
      m_ptr    = 1;
      pv_val   = 3'd4;
      pv_valid = 1;
      tick();
      sample("c11", '0, 1'b0);

      // Lockup recovery
      force dut.lfsr_cur = 10'h3FF;
      @(posedge clk);
      m_lfsr = m_step(10'h3FF);
      @(negedge clk);
      release dut.lfsr_cur;
      #1;
      check("lockup", 32'(sif.lfsr_q), 32'(m_lfsr));

      // Reset during DRAW drops the draw
      sif.req = 4'b0001;
      tick();
      sample("rd.draw", '0, 1'b1);
      reset = 1'b1;
      tick();
      m_vout   = 0;
      m_ptr    = 0;
      m_lvld   = 0;
      pv_valid = 0;
      sample("rd.reset", '0, 1'b0);
      check("rd.lfsr", 32'(sif.lfsr_q), 32'(0));
      reset = 1'b0;

      // Abort keeps the pointer; then fairness with all lines requesting
      run_txn(4'b0001, 0);
      for (int f = 0; f < 5; f++) run_txn(4'b1111, -1);

      // Randomized traffic
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 9) == 0) begin
            sif.req = '0;
            tick();
            sample("rnd_idle", '0, 1'b0);
         end else begin
            run_txn(N'($urandom_range(1, 15)),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
